// File: rtl/switch_poll_master_if.sv
// Bus bundle for the switch poller: Avalon-MM read side toward the PIO and the
// rise/fall event stream toward the timer/alarm control logic.
interface switch_poll_master_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read;
   logic              avm_waitrequest;
   logic [31:0]       avm_readdata;
   logic              avm_readdatavalid;
   logic              evt_valid;
   logic              evt_rise;
   logic              evt_ready;

   modport master (
      output avm_address, avm_read,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid,
      output evt_valid, evt_rise,
      input  evt_ready
   );

   modport slave (
      input  avm_address, avm_read,
      output avm_waitrequest, avm_readdata, avm_readdatavalid,
      input  evt_valid, evt_rise,
      output evt_ready
   );
endinterface

// File: rtl/switch_poll_master.sv
// Avalon-MM read master that periodically polls a 1-bit switch PIO, debounces the
// sampled bit across polls and reports debounced edges on a one-entry event register.
module switch_poll_master #(
   parameter int ADDR_W     = 4,
   parameter int PIO_ADDR   = 0,
   parameter int POLL_DIV   = 50000,
   parameter int DEBOUNCE_N = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  err_clr_i,
   output logic                  level_o,
   output logic                  ovf_o,
   output logic                  timeout_err_o,
   switch_poll_master_if.master  bus
);

   localparam int PC_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [PC_W-1:0] POLL_RELOAD = PC_W'(POLL_DIV - 1);
   localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
   localparam logic [3:0]      DB_MAX      = 4'(DEBOUNCE_N);

   typedef enum logic [1:0] {IDLE, READ, WAIT, UPDATE} state_e;

   state_e          state_q,    state_d;
   logic [PC_W-1:0] pollCnt_q,  pollCnt_d;
   logic [TO_W-1:0] toCnt_q,    toCnt_d;
   logic            sample_q,   sample_d;
   logic            cand_q,     cand_d;
   logic [3:0]      stable_q,   stable_d;
   logic            level_q,    level_d;
   logic            evtValid_q, evtValid_d;
   logic            evtRise_q,  evtRise_d;
   logic            ovf_q,      ovf_d;
   logic            tout_q,     tout_d;

   logic newEvt;
   logic ovfSet;
   logic toutSet;
   logic unusedReaddata;

   assign unusedReaddata = ^bus.avm_readdata[31:1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pollCnt_q  <= POLL_RELOAD;
         toCnt_q    <= '0;
         sample_q   <= 1'b0;
         cand_q     <= 1'b0;
         stable_q   <= '0;
         level_q    <= 1'b0;
         evtValid_q <= 1'b0;
         evtRise_q  <= 1'b0;
         ovf_q      <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pollCnt_q  <= pollCnt_d;
         toCnt_q    <= toCnt_d;
         sample_q   <= sample_d;
         cand_q     <= cand_d;
         stable_q   <= stable_d;
         level_q    <= level_d;
         evtValid_q <= evtValid_d;
         evtRise_q  <= evtRise_d;
         ovf_q      <= ovf_d;
         tout_q     <= tout_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pollCnt_d  = pollCnt_q;
      toCnt_d    = toCnt_q;
      sample_d   = sample_q;
      cand_d     = cand_q;
      stable_d   = stable_q;
      level_d    = level_q;
      evtValid_d = evtValid_q;
      evtRise_d  = evtRise_q;
      newEvt     = 1'b0;
      ovfSet     = 1'b0;
      toutSet    = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               if (pollCnt_q == '0) state_d = READ;
               else                 pollCnt_d = pollCnt_q - PC_W'(1);
            end
         end
         READ: begin
            if (!bus.avm_waitrequest) begin
               if (bus.avm_readdatavalid) begin
                  sample_d = bus.avm_readdata[0];
                  state_d  = UPDATE;
               end else begin
                  toCnt_d = '0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.avm_readdatavalid) begin
               sample_d = bus.avm_readdata[0];
               state_d  = UPDATE;
            end else if (toCnt_q == TO_LAST) begin
               toutSet = 1'b1;
               state_d = IDLE;
            end else begin
               toCnt_d = toCnt_q + TO_W'(1);
            end
         end
         UPDATE: begin
            if (sample_q == cand_q) begin
               stable_d = (stable_q >= DB_MAX) ? DB_MAX : stable_q + 4'd1;
            end else begin
               cand_d   = sample_q;
               stable_d = 4'd1;
            end
            if (stable_d == DB_MAX && cand_d != level_q) begin
               level_d = cand_d;
               newEvt  = 1'b1;
            end
            pollCnt_d = POLL_RELOAD;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A pending event that is not being consumed this cycle keeps priority over a new one.
      if (newEvt) begin
         if (!evtValid_q || bus.evt_ready) begin
            evtValid_d = 1'b1;
            evtRise_d  = level_d;
         end else begin
            ovfSet = 1'b1;
         end
      end else if (evtValid_q && bus.evt_ready) begin
         evtValid_d = 1'b0;
      end

      ovf_d  = ovfSet  ? 1'b1 : (err_clr_i ? 1'b0 : ovf_q);
      tout_d = toutSet ? 1'b1 : (err_clr_i ? 1'b0 : tout_q);
   end

   assign bus.avm_address = ADDR_W'(PIO_ADDR);
   assign bus.avm_read    = (state_q == READ);
   assign bus.evt_valid   = evtValid_q;
   assign bus.evt_rise    = evtRise_q;
   assign level_o         = level_q;
   assign ovf_o           = ovf_q;
   assign timeout_err_o   = tout_q;

endmodule

// File: tb/tb_switch_poll_master.sv
// Directed testbench for switch_poll_master: a behavioural PIO slave with
// programmable stall/no-response, and one task per scenario with inline checks.
module tb_switch_poll_master;

   localparam int ADDR_W     = 4;
   localparam int PIO_ADDR   = 4;
   localparam int POLL_DIV   = 4;
   localparam int DEBOUNCE_N = 4;
   localparam int TIMEOUT    = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic errClr = 1'b0;
   logic evtReady = 1'b1;
   logic level, ovf, timeoutErr;

   logic slaveBit = 1'b0;
   logic slaveNoResp = 1'b0;
   int   waitCycles = 0;
   int   waitCnt = 0;
   int   acceptCount = 0;

   int assertCount = 0;
   int failCount = 0;

   switch_poll_master_if #(.ADDR_W(ADDR_W)) bus();

   switch_poll_master #(
      .ADDR_W(ADDR_W), .PIO_ADDR(PIO_ADDR), .POLL_DIV(POLL_DIV),
      .DEBOUNCE_N(DEBOUNCE_N), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable_i(enable),
      .err_clr_i(errClr),
      .level_o(level),
      .ovf_o(ovf),
      .timeout_err_o(timeoutErr),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Slave model: stalls the first waitCycles cycles of each read, then answers in the same cycle.
   assign bus.avm_waitrequest   = bus.avm_read && (waitCnt < waitCycles);
   assign bus.avm_readdatavalid = bus.avm_read && !bus.avm_waitrequest && !slaveNoResp;
   assign bus.avm_readdata      = {31'b0, slaveBit};
   assign bus.evt_ready         = evtReady;

   always @(posedge clk) begin
      if (!bus.avm_read)            waitCnt <= 0;
      else if (bus.avm_waitrequest) waitCnt <= waitCnt + 1;
   end

   always @(negedge clk) begin
      if (bus.avm_read && !bus.avm_waitrequest) acceptCount <= acceptCount + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic resetDut;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitRead(output bit found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.avm_read) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // Completes one zero-wait poll and returns just after the edge that ends UPDATE.
   task automatic doPoll(input logic b, output bit found);
      slaveBit = b;
      waitRead(found);
      if (found) begin
         @(posedge clk);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      bit found;
      enable = 1'b1;
      waitCycles = 0;
      slaveNoResp = 1'b0;
      resetDut();
      assertCount++;
      if ({bus.avm_read, bus.evt_valid, bus.evt_rise, level, ovf, timeoutErr} !== 6'b0) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got %b expected 000000",
                  {bus.avm_read, bus.evt_valid, bus.evt_rise, level, ovf, timeoutErr});
      end
      waitCycles = 5;
      waitRead(found);
      assertCount++;
      if (found !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_first_read: got found=%0b expected 1", found);
      end
      reset = 1'b1;
      @(negedge clk);
      assertCount++;
      if (bus.avm_read !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_mid_read: avm_read=%0b expected 0", bus.avm_read);
      end
      waitCycles = 0;
      reset = 1'b0;
   endtask

   task automatic test_poll_timing;
      bit expRead;
      slaveBit = 1'b0;
      resetDut();
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) @(negedge clk);
         expRead = (i == 4 || i == 10 || i == 16);
         assertCount++;
         if (bus.avm_read !== expRead) begin
            failCount++;
            $display("[TB] FAIL poll_timing cycle %0d: avm_read=%0b expected %0b", i, bus.avm_read, expRead);
         end
      end
   endtask

   task automatic test_enable;
      resetDut();
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         assertCount++;
         if (bus.avm_read !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL enable_freeze cycle %0d: avm_read=%0b expected 0", i, bus.avm_read);
         end
      end
      enable = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         assertCount++;
         if (bus.avm_read !== (i == 4)) begin
            failCount++;
            $display("[TB] FAIL enable_resume cycle %0d: avm_read=%0b expected %0b", i, bus.avm_read, (i == 4));
         end
      end
   endtask

   task automatic test_debounce_rise;
      bit found;
      logic [2:0] expVec;
      evtReady = 1'b1;
      resetDut();
      for (int i = 0; i < 4; i++) begin
         doPoll(1'b1, found);
         expVec = (i == 3) ? 3'b111 : 3'b000;
         assertCount++;
         if ({found, bus.evt_valid, bus.evt_rise, level} !== {1'b1, expVec}) begin
            failCount++;
            $display("[TB] FAIL debounce_rise poll %0d: found,valid,rise,level=%b expected %b",
                     i + 1, {found, bus.evt_valid, bus.evt_rise, level}, {1'b1, expVec});
         end
      end
      @(posedge clk);
      #1;
      assertCount++;
      if ({bus.evt_valid, level} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL debounce_handshake: valid,level=%b expected 01", {bus.evt_valid, level});
      end
   endtask

   task automatic test_glitch_sequence;
      bit found;
      int evtCount;
      logic seq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      evtReady = 1'b1;
      evtCount = 0;
      resetDut();
      for (int i = 0; i < 7; i++) begin
         doPoll(seq[i], found);
         if (bus.evt_valid === 1'b1) evtCount++;
         assertCount++;
         if ({found, bus.evt_valid, level} !== {1'b1, (i == 6), (i == 6)}) begin
            failCount++;
            $display("[TB] FAIL glitch poll %0d: found,valid,level=%b expected %b",
                     i + 1, {found, bus.evt_valid, level}, {1'b1, (i == 6), (i == 6)});
         end
      end
      assertCount++;
      if (evtCount !== 1) begin
         failCount++;
         $display("[TB] FAIL glitch_event_count: got %0d expected 1", evtCount);
      end
   endtask

   task automatic test_waitrequest;
      bit found;
      int base;
      slaveBit = 1'b0;
      resetDut();
      waitCycles = 10;
      base = acceptCount;
      waitRead(found);
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) @(negedge clk);
         assertCount++;
         if ({found, bus.avm_read, bus.avm_address, bus.avm_waitrequest} !==
             {1'b1, 1'b1, 4'(PIO_ADDR), (c < 10)}) begin
            failCount++;
            $display("[TB] FAIL wait_hold cycle %0d: found,read,addr,wr=%b expected %b", c,
                     {found, bus.avm_read, bus.avm_address, bus.avm_waitrequest},
                     {1'b1, 1'b1, 4'(PIO_ADDR), (c < 10)});
         end
      end
      waitCycles = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         assertCount++;
         if (bus.avm_read !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL wait_no_dup cycle %0d: avm_read=%0b expected 0", c, bus.avm_read);
         end
      end
      assertCount++;
      if (acceptCount - base !== 1) begin
         failCount++;
         $display("[TB] FAIL wait_accept_count: got %0d expected 1", acceptCount - base);
      end
   endtask

   task automatic test_timeout;
      bit found;
      slaveBit = 1'b0;
      resetDut();
      slaveNoResp = 1'b1;
      waitRead(found);
      assertCount++;
      if (found !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL timeout_read_start: got found=%0b expected 1", found);
      end
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         assertCount++;
         if ({bus.avm_read, timeoutErr} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL timeout_wait cycle %0d: read,terr=%b expected 00", c, {bus.avm_read, timeoutErr});
         end
      end
      @(negedge clk);
      assertCount++;
      if (timeoutErr !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL timeout_set: timeout_err=%0b expected 1", timeoutErr);
      end
      slaveNoResp = 1'b0;
      doPoll(1'b1, found);
      assertCount++;
      if ({found, timeoutErr} !== 2'b11) begin
         failCount++;
         $display("[TB] FAIL timeout_next_poll: found,terr=%b expected 11", {found, timeoutErr});
      end
      @(negedge clk);
      errClr = 1'b1;
      @(negedge clk);
      errClr = 1'b0;
      assertCount++;
      if (timeoutErr !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL timeout_clear: timeout_err=%0b expected 0", timeoutErr);
      end
   endtask

   task automatic test_overflow;
      bit found;
      evtReady = 1'b0;
      resetDut();
      for (int i = 0; i < 4; i++) doPoll(1'b1, found);
      assertCount++;
      if ({found, bus.evt_valid, bus.evt_rise, level, ovf} !== 5'b11110) begin
         failCount++;
         $display("[TB] FAIL ovf_rise_pending: found,valid,rise,level,ovf=%b expected 11110",
                  {found, bus.evt_valid, bus.evt_rise, level, ovf});
      end
      for (int i = 0; i < 3; i++) doPoll(1'b0, found);
      assertCount++;
      if ({level, ovf} !== 2'b10) begin
         failCount++;
         $display("[TB] FAIL ovf_before_fall: level,ovf=%b expected 10", {level, ovf});
      end
      doPoll(1'b0, found);
      assertCount++;
      if ({found, bus.evt_valid, bus.evt_rise, level, ovf} !== 5'b11101) begin
         failCount++;
         $display("[TB] FAIL ovf_fall_dropped: found,valid,rise,level,ovf=%b expected 11101",
                  {found, bus.evt_valid, bus.evt_rise, level, ovf});
      end
      evtReady = 1'b1;
      @(posedge clk);
      #1;
      assertCount++;
      if ({bus.evt_valid, ovf} !== 2'b01) begin
         failCount++;
         $display("[TB] FAIL ovf_drain: valid,ovf=%b expected 01", {bus.evt_valid, ovf});
      end
      @(negedge clk);
      errClr = 1'b1;
      @(negedge clk);
      errClr = 1'b0;
      assertCount++;
      if (ovf !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL ovf_clear: ovf=%0b expected 0", ovf);
      end
   endtask

   initial begin
      test_reset();
      test_poll_timing();
      test_enable();
      test_debounce_rise();
      test_glitch_sequence();
      test_waitrequest();
      test_timeout();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
